bist_seq_controller: RTL and testbench
======================================

Name: bist_seq_controller

Overview:
- Parametrised next-generation BIST sequencing controller.
- Accepts a start request and runs an init phase, then N test passes over a 2^CNT_W vector address space, with a toggle phase between passes, then a finish phase, and latches a sticky done flag.
- Sits between the top-level test-mode logic and the pattern generator / response compactor. It drives their phase strobes and the vector address.

Parameters:
- CNT_W, 4, vector address counter width; each pass lasts 2^CNT_W cycles.
- N_PASSES, 2, number of RUN passes per session (>=1).
- INIT_CYCLES, 1, cycles spent in INIT (>=1).
- PASS_W, 1, width of pass_idx; must satisfy 2^PASS_W >= N_PASSES.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  session request, sampled at posedge; level or pulse.
- init  output  1  high while in INIT.
- running  output  1  high while in RUN.
- toggle  output  1  one-cycle strobe between passes.
- finish  output  1  one-cycle strobe at session end.
- bist_end  output  1  sticky done flag.
- busy  output  1  high in any state other than IDLE.
- cnt  output  CNT_W  vector address, valid while running.
- pass_idx  output  PASS_W  current pass number, 0-based.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset (async assert, sync release) forces state IDLE and cnt=0, pass_idx=0, init=running=toggle=finish=busy=bist_end=0.
- All outputs are registered and decoded from the state register. There is no combinational path from any input to any output.
- State machine, one transition per posedge:
  - IDLE: start=1 -> INIT; init_cnt=0, cnt=0, pass_idx=0, bist_end cleared.
  - INIT: init=1. Stays for INIT_CYCLES cycles, then -> RUN.
  - RUN: running=1; cnt increments by 1 each cycle. When cnt==2^CNT_W-1:
    - if pass_idx==N_PASSES-1 -> FINISH;
    - else -> TOGGLE.
  - TOGGLE: toggle=1 for one cycle; pass_idx+1, cnt=0 -> RUN.
  - FINISH: finish=1 for one cycle -> IDLE; bist_end set to 1.
- cnt wraps naturally at 2^CNT_W. No extra cycle is added at the terminal count.
- start is ignored in every state except IDLE. A mid-session start has no effect on timing or outputs.
- start held high continuously: a new session begins on the first posedge after FINISH returns to IDLE, i.e. back-to-back sessions with one IDLE cycle between them. bist_end is high during that IDLE cycle and is cleared when INIT is entered.
- reset and start both high: reset wins. After reset releases, start still high is accepted at the next posedge.
- Reset mid-session aborts immediately (async) to IDLE with bist_end=0.
- Session length from acceptance to FINISH exit: INIT_CYCLES + N_PASSES*2^CNT_W + (N_PASSES-1) + 1 cycles. With defaults this is 35 cycles.

Optional Feature:
- Macro BIST_ABORT_EN.
- When defined, adds input port abort (1 bit) and output port aborted (1 bit, sticky).
  - abort=1 sampled in INIT, RUN or TOGGLE -> IDLE next cycle; aborted=1, bist_end stays 0, finish is not asserted.
  - aborted is cleared on the next accepted start or on reset.
  - abort is ignored in IDLE and FINISH.
  - If start and abort are high in the same IDLE cycle, start is accepted.
- When undefined, neither port exists and the behaviour is exactly as above.

Decomposition:
- Shared package/header bist_pkg holds:
  - state encoding constants ST_IDLE, ST_INIT, ST_RUN, ST_TOGGLE, ST_FINISH (3-bit binary);
  - a helper function for the terminal count value.
- One sub-module, bist_addr_counter: parametrised CNT_W up-counter with sync clear, enable, and terminal-count flag. It is reused for the INIT cycle count with its own width.

Test Plan (defaults, 10 ns clock):
- Reset pulse, then 1-cycle start -> init for 1 cycle; running for 16 cycles with cnt 0..15; toggle 1 cycle with pass_idx=1; running 16 cycles; finish 1 cycle; bist_end=1 thereafter. Total 35 busy cycles.
- Second start after bist_end -> bist_end drops on INIT entry; the session repeats identically.
- start pulsed while running in pass 0 at cnt=3 -> no change; finish occurs at the same cycle as an undisturbed run.
- reset and start asserted together for 2 cycles, reset released first, start released a cycle later -> held in IDLE during reset, session begins on the first posedge after reset release.
- reset asserted for 3 ns at cnt=1 in pass 0 -> all outputs 0 immediately (async); later start runs a full 35-cycle session.
- With BIST_ABORT_EN: abort at cnt=7 in pass 1 -> IDLE next cycle, aborted=1, finish never pulses, bist_end=0.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST sequencing controller.
//   state_t    : controller state encoding (3-bit binary)
//   term_count : all-ones terminal value of a counter of a given width
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_RUN    = 3'd2,
    ST_TOGGLE = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  function automatic int unsigned term_count(input int unsigned w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/bist_addr_counter.sv
// Up-counter with synchronous clear, count enable and terminal-count flag.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous clear (has priority over en)
//   en         : count enable, wraps naturally at 2^CNT_W
//   q          : current count
//   tc         : high while q equals LAST
module bist_addr_counter
  import bist_pkg::*;
#(
  parameter int unsigned      CNT_W = 4,
  parameter logic [CNT_W-1:0] LAST  = CNT_W'(term_count(CNT_W))
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] q,
  output logic             tc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + CNT_W'(1);
    end
  end

  assign tc = (q == LAST);

endmodule

// File: rtl/bist_seq_controller.sv
// BIST sequencing controller: on start runs INIT, then N_PASSES passes over
// a 2^CNT_W vector address space separated by one-cycle TOGGLE strobes, then
// a one-cycle FINISH strobe, and latches a sticky bist_end flag.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   start      : session request (honoured only in IDLE)
//   init, running, toggle, finish : registered phase strobes
//   bist_end   : sticky done flag, cleared when the next session starts
//   busy       : high in every state except IDLE
//   cnt        : vector address, valid while running
//   pass_idx   : current pass number, 0-based
// Optional (macro BIST_ABORT_EN):
//   abort      : abandons the session from INIT, RUN or TOGGLE
//   aborted    : sticky abort flag, cleared on the next accepted start
module bist_seq_controller
  import bist_pkg::*;
#(
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned N_PASSES    = 2,
  parameter int unsigned INIT_CYCLES = 1,
  parameter int unsigned PASS_W      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              init,
  output logic              running,
  output logic              toggle,
  output logic              finish,
  output logic              bist_end,
  output logic              busy,
  output logic [CNT_W-1:0]  cnt,
  output logic [PASS_W-1:0] pass_idx
`ifdef BIST_ABORT_EN
  ,
  input  logic              abort,
  output logic              aborted
`endif
);

  localparam int unsigned       INIT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(N_PASSES - 1);

  state_t            state;
  state_t            nxt;
  logic              init_tc;
  logic              cnt_tc;
  logic              abort_hit;
  // Only the terminal flag of the INIT counter matters.
  logic [INIT_W-1:0] init_q_unused;

  bist_addr_counter #(
    .CNT_W (CNT_W)
  ) u_addr_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state != ST_RUN),
    .en    (state == ST_RUN),
    .q     (cnt),
    .tc    (cnt_tc)
  );

  bist_addr_counter #(
    .CNT_W (INIT_W),
    .LAST  (INIT_LAST)
  ) u_init_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state != ST_INIT),
    .en    (state == ST_INIT),
    .q     (init_q_unused),
    .tc    (init_tc)
  );

`ifdef BIST_ABORT_EN
  assign abort_hit = abort &&
                     ((state == ST_INIT) || (state == ST_RUN) || (state == ST_TOGGLE));
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (start) nxt = ST_INIT;
      ST_INIT: begin
        if (abort_hit)    nxt = ST_IDLE;
        else if (init_tc) nxt = ST_RUN;
      end
      ST_RUN: begin
        if (abort_hit)   nxt = ST_IDLE;
        else if (cnt_tc) nxt = (pass_idx == LAST_PASS) ? ST_FINISH : ST_TOGGLE;
      end
      ST_TOGGLE: nxt = abort_hit ? ST_IDLE : ST_RUN;
      ST_FINISH: nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next-state decode so that they are
  // aligned with the state they describe and never see an input directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      init     <= 1'b0;
      running  <= 1'b0;
      toggle   <= 1'b0;
      finish   <= 1'b0;
      busy     <= 1'b0;
      bist_end <= 1'b0;
      pass_idx <= '0;
    end else begin
      state   <= nxt;
      init    <= (nxt == ST_INIT);
      running <= (nxt == ST_RUN);
      toggle  <= (nxt == ST_TOGGLE);
      finish  <= (nxt == ST_FINISH);
      busy    <= (nxt != ST_IDLE);
      if (state == ST_IDLE && nxt == ST_INIT) begin
        pass_idx <= '0;
      end else if (nxt == ST_TOGGLE) begin
        pass_idx <= pass_idx + PASS_W'(1);
      end
      if (state == ST_IDLE && nxt == ST_INIT) begin
        bist_end <= 1'b0;
      end else if (state == ST_FINISH) begin
        bist_end <= 1'b1;
      end
    end
  end

`ifdef BIST_ABORT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aborted <= 1'b0;
    end else if (state == ST_IDLE && nxt == ST_INIT) begin
      aborted <= 1'b0;
    end else if (abort_hit) begin
      aborted <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bist_seq_controller.sv
module tb_bist_seq_controller;

  localparam int CNT_W       = 4;
  localparam int N_PASSES    = 2;
  localparam int INIT_CYCLES = 1;
  localparam int PASS_W      = 1;
  localparam int SPAN        = 1 << CNT_W;
  localparam int SLEN        = INIT_CYCLES + N_PASSES * SPAN + (N_PASSES - 1) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              init, running, toggle, finish, bist_end, busy;
  logic [CNT_W-1:0]  cnt;
  logic [PASS_W-1:0] pass_idx;
`ifdef BIST_ABORT_EN
  logic              abort = 1'b0;
  logic              aborted;
`endif

  always #5 clk = ~clk;

  bist_seq_controller #(
    .CNT_W       (CNT_W),
    .N_PASSES    (N_PASSES),
    .INIT_CYCLES (INIT_CYCLES),
    .PASS_W      (PASS_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .init     (init),
    .running  (running),
    .toggle   (toggle),
    .finish   (finish),
    .bist_end (bist_end),
    .busy     (busy),
    .cnt      (cnt),
    .pass_idx (pass_idx)
`ifdef BIST_ABORT_EN
    ,
    .abort    (abort),
    .aborted  (aborted)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a session is described only by its position m_k
  // (1..SLEN) counted from the accepting edge.
  bit m_act = 1'b0;
  int m_k   = 0;
  bit m_be  = 1'b0;
  bit m_ab  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 1'b0; m_k = 0; m_be = 1'b0; m_ab = 1'b0;
  endtask

  task automatic model_edge();
    bit abt;
    abt = 1'b0;
`ifdef BIST_ABORT_EN
    abt = abort;
`endif
    if (reset) begin
      model_reset();
    end else if (m_act) begin
      if (abt && m_k != SLEN) begin
        m_act = 1'b0; m_ab = 1'b1;
      end else if (m_k == SLEN) begin
        m_act = 1'b0; m_be = 1'b1;
      end else begin
        m_k++;
      end
    end else if (start) begin
      m_act = 1'b1; m_k = 1; m_be = 1'b0; m_ab = 1'b0;
    end
  endtask

  task automatic check_outputs();
    int ei, er, et, ef, ec, ep, r, p, o;
    ei = 0; er = 0; et = 0; ef = 0; ec = 0; ep = 0;
    if (m_act) begin
      if (m_k <= INIT_CYCLES) ei = 1;
      else begin
        r = m_k - INIT_CYCLES - 1;
        p = r / (SPAN + 1);
        o = r % (SPAN + 1);
        if (o < SPAN) begin er = 1; ec = o; ep = p; end
        else if (p == N_PASSES - 1) ef = 1;
        else begin et = 1; ep = p + 1; end
      end
    end
    chk("init", init, ei);
    chk("running", running, er);
    chk("toggle", toggle, et);
    chk("finish", finish, ef);
    chk("busy", busy, m_act);
    chk("bist_end", bist_end, m_be);
    if (er != 0) chk("cnt", cnt, ec);
    if (er != 0 || et != 0) chk("pass_idx", pass_idx, ep);
`ifdef BIST_ABORT_EN
    chk("aborted", aborted, m_ab);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_run(input int p, input int c, input string tag);
    int i;
    i = 0;
    while (!(running === 1'b1 && int'(pass_idx) == p && int'(cnt) == c) && i < 100) begin
      step();
      i++;
    end
    chk(tag, (i < 100), 1);
  endtask

  // Starts a session and counts busy cycles; optionally pulses start once
  // at pass 0 / cnt 3 to show it is ignored mid-session.
  task automatic run_session(input bit poke, input string tag);
    int n;
    bit poked;
    poked = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      start = 1'b0;
      if (poke && running === 1'b1 && pass_idx == '0 && int'(cnt) == 3) begin
        start = 1'b1;
        poked = 1'b1;
      end
      n++;
      step();
    end
    start = 1'b0;
    chk(tag, n, SLEN);
    if (poke) chk("poke_hit", poked, 1);
  endtask

  initial begin
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    chk("reset_cnt", cnt, 0);
    chk("reset_pass", pass_idx, 0);
    reset = 1'b0;
    step();

    // Plain session, then a second one after bist_end.
    run_session(1'b0, "len_first");
    step();
    step();
    run_session(1'b0, "len_second");
    step();

    // Mid-session start must not shift the finish cycle.
    run_session(1'b1, "len_poked");
    step();

    // reset and start together: held in IDLE, accepted after release.
    reset = 1'b1;
    start = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    chk("start_after_reset", init, 1);
    start = 1'b0;
    for (int i = 0; i < 100 && busy === 1'b1; i++) step();

    // Asynchronous reset in the middle of pass 0.
    start = 1'b1;
    step();
    start = 1'b0;
    wait_run(0, 1, "wait_cnt1");
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("async_cnt", cnt, 0);
    chk("async_pass", pass_idx, 0);
    #2;
    reset = 1'b0;
    step();
    run_session(1'b0, "len_after_abort_reset");

`ifdef BIST_ABORT_EN
    // Abort late in pass 1: back to IDLE, no finish, no bist_end.
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_run(1, 7, "wait_p1c7");
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", busy, 0);
    chk("abort_flag", aborted, 1);
    chk("abort_bist_end", bist_end, 0);
    step();
`endif

    // Randomized start (and abort) activity against the model.
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 9) == 0);
`ifdef BIST_ABORT_EN
      abort = ($urandom_range(0, 59) == 0);
`endif
      step();
    end
    start = 1'b0;
`ifdef BIST_ABORT_EN
    abort = 1'b0;
`endif
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
